arp_decode: RTL and testbench

Receive-side ARP parser and counterpart of the ARP reply encoder. It consumes the 28-byte ARP payload one byte per cycle, after Ethernet header stripping, and checks the fixed header fields. It captures SHA/SPA/THA/TPA and flags requests addressed to our IP, so the TX path can build a reply using the captured SHA/SPA as its target addresses. Replies addressed to our MAC/IP are flagged for the address cache.

---
 rtl/arp_decode.sv | 209 ++++++++++++++++++++
 tb/tb_arp_decode.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_decode.sv
// Receive-side ARP parser: validates the fixed header byte by byte, captures the
// sender/target addresses, and flags requests and replies addressed to this station.
`timescale 1ns/1ps
module arp_decode #(
    parameter logic [47:0] MAC_ADDR = 48'h0,
    parameter logic [31:0] IP_ADDR  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        din_valid,
    input  logic [7:0]  din,
    output logic        done,
    output logic        is_request,
    output logic        is_reply,
    output logic [47:0] sha,
    output logic [31:0] spa,
    output logic [47:0] tha,
    output logic        err
);

    localparam int unsigned CNT_W     = 5;
    localparam int unsigned PKT_BYTES = 28;
    localparam int unsigned LAST_HDR  = 7;
    localparam int unsigned LAST_BYTE = 27;
    localparam int unsigned SHA_LO    = 8;
    localparam int unsigned SPA_LO    = 14;
    localparam int unsigned THA_LO    = 18;
    localparam int unsigned TPA_LO    = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ADDR,
        S_HOLD,
        S_DROP
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               sync_q;
    logic               oper_req_q;
    logic [47:0]        sha_sh_q;
    logic [31:0]        spa_sh_q;
    logic [47:0]        tha_sh_q;
    logic [23:0]        tpa_sh_q;

    logic               done_q;
    logic               err_q;
    logic               is_request_q;
    logic               is_reply_q;
    logic [47:0]        sha_q;
    logic [31:0]        spa_q;
    logic [47:0]        tha_q;

    logic               acc_c;
    logic               hdr_ok_c;
    logic               match_c;
    logic [31:0]        tpa_c;

    assign acc_c = en && din_valid;

    // Saturating byte counter increment.
    assign cnt_d = (cnt_q == CNT_W'(PKT_BYTES)) ? cnt_q : cnt_q + CNT_W'(1);

    // Expected value of each fixed header byte at its position.
    always_comb begin
        hdr_ok_c = 1'b1;
        case (cnt_q)
            CNT_W'(0): hdr_ok_c = (din == 8'h00);
            CNT_W'(1): hdr_ok_c = (din == 8'h01);
            CNT_W'(2): hdr_ok_c = (din == 8'h08);
            CNT_W'(3): hdr_ok_c = (din == 8'h00);
            CNT_W'(4): hdr_ok_c = (din == 8'h06);
            CNT_W'(5): hdr_ok_c = (din == 8'h04);
            CNT_W'(6): hdr_ok_c = (din == 8'h00);
            CNT_W'(7): hdr_ok_c = (din == 8'h01) || (din == 8'h02);
            default:   hdr_ok_c = 1'b1;
        endcase
    end

    // TPA completes with the byte on the bus; replies must also target our MAC.
    assign tpa_c   = {tpa_sh_q, din};
    assign match_c = (tpa_c == IP_ADDR) && (oper_req_q || (tha_sh_q == MAC_ADDR));

    // Address shadows shift in MSB first as their bytes arrive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sha_sh_q <= 48'h0;
            spa_sh_q <= 32'h0;
            tha_sh_q <= 48'h0;
            tpa_sh_q <= 24'h0;
        end else if (acc_c) begin
            if (cnt_q >= CNT_W'(SHA_LO) && cnt_q < CNT_W'(SPA_LO)) begin
                sha_sh_q <= {sha_sh_q[39:0], din};
            end
            if (cnt_q >= CNT_W'(SPA_LO) && cnt_q < CNT_W'(THA_LO)) begin
                spa_sh_q <= {spa_sh_q[23:0], din};
            end
            if (cnt_q >= CNT_W'(THA_LO) && cnt_q < CNT_W'(TPA_LO)) begin
                tha_sh_q <= {tha_sh_q[39:0], din};
            end
            if (cnt_q >= CNT_W'(TPA_LO) && cnt_q < CNT_W'(LAST_BYTE)) begin
                tpa_sh_q <= {tpa_sh_q[15:0], din};
            end
        end
    end

    // Parser FSM with registered pulses and captured addresses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sync_q       <= 1'b1;
            oper_req_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            is_request_q <= 1'b0;
            is_reply_q   <= 1'b0;
            sha_q        <= 48'h0;
            spa_q        <= 32'h0;
            tha_q        <= 48'h0;
        end else begin
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            is_request_q <= 1'b0;
            is_reply_q   <= 1'b0;
            sync_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    // A frame already in flight when reset released is skipped silently.
                    if (en && sync_q) begin
                        state_q <= S_DROP;
                    end else if (acc_c) begin
                        cnt_q <= CNT_W'(1);
                        if (!hdr_ok_c) begin
                            state_q <= S_DROP;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_HDR;
                        end
                    end
                end
                S_HDR: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                    end else if (din_valid) begin
                        cnt_q <= cnt_d;
                        if (!hdr_ok_c) begin
                            state_q <= S_DROP;
                            err_q   <= 1'b1;
                        end else if (cnt_q == CNT_W'(LAST_HDR)) begin
                            oper_req_q <= (din == 8'h01);
                            state_q    <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                    end else if (din_valid) begin
                        cnt_q <= cnt_d;
                        if (cnt_q == CNT_W'(LAST_BYTE)) begin
                            if (match_c) begin
                                state_q      <= S_HOLD;
                                done_q       <= 1'b1;
                                is_request_q <= oper_req_q;
                                is_reply_q   <= !oper_req_q;
                                sha_q        <= sha_sh_q;
                                spa_q        <= spa_sh_q;
                                tha_q        <= tha_sh_q;
                            end else begin
                                state_q <= S_DROP;
                                err_q   <= 1'b1;
                            end
                        end
                    end
                end
                S_HOLD, S_DROP: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (din_valid) begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign done       = done_q;
    assign err        = err_q;
    assign is_request = is_request_q;
    assign is_reply   = is_reply_q;
    assign sha        = sha_q;
    assign spa        = spa_q;
    assign tha        = tha_q;

endmodule

// File: tb/tb_arp_decode.sv
// Bench for arp_decode: directed vector table, reset/resync sequence, and random
// frames checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_arp_decode;

    localparam logic [47:0] MAC = 48'h02AABBCCDDEE;
    localparam logic [31:0] IP  = 32'hC0A80164;

    localparam logic [3:0] P_NONE = 4'b0000;
    localparam logic [3:0] P_REQ  = 4'b1010;
    localparam logic [3:0] P_REP  = 4'b1001;
    localparam logic [3:0] P_ERR  = 4'b0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        din_valid;
    logic [7:0]  din;
    logic        done;
    logic        is_request;
    logic        is_reply;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic        err;

    always #5 clk = ~clk;

    arp_decode #(.MAC_ADDR(MAC), .IP_ADDR(IP)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din_valid  (din_valid),
        .din        (din),
        .done       (done),
        .is_request (is_request),
        .is_reply   (is_reply),
        .sha        (sha),
        .spa        (spa),
        .tha        (tha),
        .err        (err)
    );

    typedef struct {
        logic [15:0] htype;
        logic [15:0] ptype;
        logic [7:0]  hlen;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
        int          len;
        int          pct;
        int          dec;
        logic [3:0]  pv;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [47:0] exp_sha  = 48'h0;
    logic [31:0] exp_spa  = 32'h0;
    logic [47:0] exp_tha  = 48'h0;
    logic [7:0]  frm[$];
    vec_t        vecs[12];

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then compare outputs at the following negedge.
    task automatic cyc(input string name, input logic e, input logic v, input logic [7:0] d,
                       input logic [3:0] pulse, input logic [47:0] nsha,
                       input logic [31:0] nspa, input logic [47:0] ntha);
        en = e;
        din_valid = v;
        din = d;
        @(negedge clk);
        if (pulse[3]) begin
            exp_sha = nsha;
            exp_spa = nspa;
            exp_tha = ntha;
        end
        check(name, {done, err, is_request, is_reply, sha, spa, tha},
              {pulse, exp_sha, exp_spa, exp_tha});
    endtask

    task automatic push_field(input logic [47:0] x, input int nb);
        for (int i = nb - 1; i >= 0; i--) frm.push_back(8'(x >> (8 * i)));
    endtask

    task automatic build(input logic [15:0] htype, input logic [15:0] ptype, input logic [7:0] hlen,
                         input logic [15:0] oper, input logic [47:0] s, input logic [31:0] p,
                         input logic [47:0] t, input logic [31:0] tp, input int len);
        frm.delete();
        push_field(48'(htype), 2);
        push_field(48'(ptype), 2);
        push_field(48'(hlen), 1);
        push_field(48'h04, 1);
        push_field(48'(oper), 2);
        push_field(s, 6);
        push_field(48'(p), 4);
        push_field(t, 6);
        push_field(48'(tp), 4);
        while (frm.size() < len) frm.push_back(8'($urandom));
        while (frm.size() > len) void'(frm.pop_back());
    endtask

    // Reference: decide outcome from the byte list using the ARP field layout.
    task automatic model(output int dec, output logic [3:0] pv, output logic [47:0] ms,
                         output logic [31:0] mp, output logic [47:0] mt);
        logic [7:0]  hdr [7];
        logic [31:0] tp;
        hdr = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00};
        dec = -1;
        pv  = P_ERR;
        ms  = 48'h0;
        mp  = 32'h0;
        mt  = 48'h0;
        tp  = 32'h0;
        for (int i = 0; i < frm.size() && i < 8; i++) begin
            if ((i < 7 && frm[i] != hdr[i]) ||
                (i == 7 && frm[i] != 8'h01 && frm[i] != 8'h02)) begin
                dec = i;
                return;
            end
        end
        if (frm.size() < 28) return;
        for (int i = 8; i < 14; i++)  ms = {ms[39:0], frm[i]};
        for (int i = 14; i < 18; i++) mp = {mp[23:0], frm[i]};
        for (int i = 18; i < 24; i++) mt = {mt[39:0], frm[i]};
        for (int i = 24; i < 28; i++) tp = {tp[23:0], frm[i]};
        dec = 27;
        if (tp == IP && (frm[7] == 8'h01 || mt == MAC))
            pv = (frm[7] == 8'h01) ? P_REQ : P_REP;
    endtask

    // Stream the frame with random din_valid gaps, then drop en for one cycle.
    task automatic run_frame(input string name, input int pct, input int dec, input logic [3:0] pv,
                             input logic [47:0] s, input logic [31:0] p, input logic [47:0] t);
        int i;
        int stall;
        logic v;
        i = 0;
        stall = 0;
        while (i < frm.size()) begin
            v = ($urandom_range(0, 99) < pct) || (stall >= 3);
            if (v) begin
                cyc(name, 1'b1, 1'b1, frm[i], (i == dec) ? pv : P_NONE, s, p, t);
                i++;
                stall = 0;
            end else begin
                cyc(name, 1'b1, 1'b0, 8'($urandom), P_NONE, s, p, t);
                stall++;
            end
        end
        cyc({name, "_end"}, 1'b0, 1'b0, 8'h00, (dec < 0) ? pv : P_NONE, s, p, t);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int          dec;
        logic [3:0]  pv;
        logic [47:0] ms, mt;
        logic [31:0] mp;

        vecs[0]  = '{16'h0001, 16'h0800, 8'h06, 16'h0001, 48'h021122334455, 32'hC0A80102, 48'h0,        IP,           28, 100, 27, P_REQ};
        vecs[1]  = '{16'h0001, 16'h0800, 8'h06, 16'h0002, 48'h0A0B0C0D0E0F, 32'hC0A80105, MAC,          IP,           28, 100, 27, P_REP};
        vecs[2]  = '{16'h0001, 16'h0800, 8'h06, 16'h0002, 48'h0A0B0C0D0E0F, 32'hC0A80105, MAC ^ 48'h1,  IP,           28, 100, 27, P_ERR};
        vecs[3]  = '{16'h0006, 16'h0800, 8'h06, 16'h0001, 48'h021122334455, 32'hC0A80102, 48'h0,        IP,           40, 100, 1,  P_ERR};
        vecs[4]  = '{16'h0001, 16'h0806, 8'h06, 16'h0001, 48'h021122334455, 32'hC0A80102, 48'h0,        IP,           28, 100, 3,  P_ERR};
        vecs[5]  = '{16'h0001, 16'h0800, 8'h05, 16'h0001, 48'h021122334455, 32'hC0A80102, 48'h0,        IP,           28, 100, 4,  P_ERR};
        vecs[6]  = '{16'h0001, 16'h0800, 8'h06, 16'h0003, 48'h021122334455, 32'hC0A80102, 48'h0,        IP,           28, 100, 7,  P_ERR};
        vecs[7]  = '{16'h0001, 16'h0800, 8'h06, 16'h0101, 48'h021122334455, 32'hC0A80102, 48'h0,        IP,           28, 100, 6,  P_ERR};
        vecs[8]  = '{16'h0001, 16'h0800, 8'h06, 16'h0001, 48'h021122334455, 32'hC0A80102, 48'h0,        32'hC0A80165, 28, 100, 27, P_ERR};
        vecs[9]  = '{16'h0001, 16'h0800, 8'h06, 16'h0001, 48'h0CAFEF00D123, 32'hC0A80177, 48'h0,        IP,           20, 100, -1, P_ERR};
        vecs[10] = '{16'h0001, 16'h0800, 8'h06, 16'h0001, 48'h021122334455, 32'hC0A80102, 48'h0,        IP,           28, 50,  27, P_REQ};
        vecs[11] = '{16'h0001, 16'h0800, 8'h06, 16'h0001, 48'h0CCCCCCCCCCC, 32'hC0A80109, 48'h0,        IP,           46, 100, 27, P_REQ};

        rst = 1'b0;
        en = 1'b0;
        din_valid = 1'b0;
        din = 8'h00;
        cyc("reset0", 1'b0, 1'b0, 8'h00, P_NONE, 48'h0, 32'h0, 48'h0);
        cyc("reset1", 1'b1, 1'b1, 8'h00, P_NONE, 48'h0, 32'h0, 48'h0);
        rst = 1'b1;
        cyc("idle", 1'b0, 1'b0, 8'h00, P_NONE, 48'h0, 32'h0, 48'h0);

        for (int k = 0; k < 12; k++) begin
            build(vecs[k].htype, vecs[k].ptype, vecs[k].hlen, vecs[k].oper, vecs[k].sha,
                  vecs[k].spa, vecs[k].tha, vecs[k].tpa, vecs[k].len);
            run_frame($sformatf("vec%0d", k), vecs[k].pct, vecs[k].dec, vecs[k].pv,
                      vecs[k].sha, vecs[k].spa, vecs[k].tha);
        end

        // Reset in the middle of a frame, then resync on the next en low.
        build(16'h0001, 16'h0800, 8'h06, 16'h0001, 48'h06FEDCBA9876, 32'hC0A80111, 48'h0, IP, 28);
        for (int i = 0; i <= 12; i++)
            cyc("rst_pre", 1'b1, 1'b1, frm[i], P_NONE, 48'h0, 32'h0, 48'h0);
        en = 1'b1;
        din_valid = 1'b1;
        din = frm[13];
        rst = 1'b0;
        #1;
        exp_sha = 48'h0;
        exp_spa = 32'h0;
        exp_tha = 48'h0;
        check("rst_async", {done, err, is_request, is_reply, sha, spa, tha},
              {P_NONE, exp_sha, exp_spa, exp_tha});
        @(negedge clk);
        rst = 1'b1;
        for (int i = 13; i < 28; i++)
            cyc("rst_resync", 1'b1, 1'b1, frm[i], P_NONE, 48'h0, 32'h0, 48'h0);
        cyc("rst_enlow", 1'b0, 1'b0, 8'h00, P_NONE, 48'h0, 32'h0, 48'h0);
        run_frame("rst_next", 100, 27, P_REQ, 48'h06FEDCBA9876, 32'hC0A80111, 48'h0);

        for (int k = 0; k < 40; k++) begin
            int          mode;
            int          len;
            logic [15:0] op;
            logic [47:0] s, t;
            logic [31:0] p, tp;
            mode = $urandom_range(0, 5);
            s  = {16'($urandom), $urandom};
            p  = $urandom;
            op = (mode == 1 || mode == 2) ? 16'h0002 : 16'h0001;
            t  = (mode == 1) ? MAC : {16'($urandom), $urandom};
            tp = (mode == 5) ? (IP ^ (32'h1 << $urandom_range(0, 31))) : IP;
            len = (mode == 4) ? $urandom_range(1, 27) : 28 + $urandom_range(0, 10);
            build(16'h0001, 16'h0800, 8'h06, op, s, p, t, tp, len);
            if (mode == 3) begin
                int idx;
                idx = $urandom_range(0, 27);
                frm[idx] = frm[idx] ^ 8'(1 << $urandom_range(0, 7));
            end
            model(dec, pv, ms, mp, mt);
            run_frame($sformatf("rnd%0d_m%0d", k, mode), $urandom_range(30, 100), dec, pv, ms, mp, mt);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
